// File: rtl/vga_pix_reader.sv
// VGA 640x480@60 scan initiator: issues one read per pixel tick to the colour-channel
// pixel memories and drives the DAC with the answers, aligned with sync and blank.
module vga_pix_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [31:0] indxpix,
  output logic [31:0] indypix,
  output logic [31:0] indpix,
  output logic        write_en,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d, h_req_q, h_req_d;
  logic [VW-1:0] v_q, v_d, v_req_q, v_req_d;
  logic          vis_req_q, vis_req_d;
  logic [31:0]   x_q, x_d, y_q, y_d, ind_q, ind_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic          fs_q, fs_d, vclk_q, vclk_d;
  logic          tick, go, visible;

  assign tick    = (div_q == DIV_LAST);
  assign visible = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    div_d     = tick ? '0 : div_q + DW'(1);
    h_d       = h_q;
    v_d       = v_q;
    h_req_d   = h_req_q;
    v_req_d   = v_req_q;
    vis_req_d = vis_req_q;
    x_d       = x_q;
    y_d       = y_q;
    ind_d     = ind_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    fs_d      = 1'b0;

    case (state_q)
      IDLE: if (tick && en) begin
        state_d = SCAN;
        go      = 1'b1;
      end
      SCAN: if (tick) begin
        go = 1'b1;
        // en is only honoured at the end of a frame, so a frame is never cut short
        if (h_q == H_LAST && v_q == V_LAST && !en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
      x_d       = visible ? 32'(h_q) : 32'd0;
      y_d       = visible ? 32'(v_q) : 32'd0;
      ind_d     = visible ? 32'(h_q) + 32'(v_q) * 32'(H_ACTIVE) : 32'd0;
      h_req_d   = h_q;
      v_req_d   = v_q;
      vis_req_d = visible;
      // Capture stage works on the previous request, whose memory answer is now stable
      r_d       = vis_req_q ? pix_r : 8'd0;
      g_d       = vis_req_q ? pix_g : 8'd0;
      b_d       = vis_req_q ? pix_b : 8'd0;
      hs_d      = !(h_req_q >= HS_BEG && h_req_q <= HS_END);
      vs_d      = !(v_req_q >= VS_BEG && v_req_q <= VS_END);
      blank_n_d = vis_req_q;
      fs_d      = (h_q == '0) && (v_q == '0);
    end else if (tick) begin
      h_req_d   = '0;
      v_req_d   = '0;
      vis_req_d = 1'b0;
      x_d       = 32'd0;
      y_d       = 32'd0;
      ind_d     = 32'd0;
      r_d       = 8'd0;
      g_d       = 8'd0;
      b_d       = 8'd0;
      hs_d      = 1'b1;
      vs_d      = 1'b1;
      blank_n_d = 1'b0;
    end

    vclk_d = (state_d == SCAN) && (div_d < DIV_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      h_req_q   <= '0;
      v_req_q   <= '0;
      vis_req_q <= 1'b0;
      x_q       <= 32'd0;
      y_q       <= 32'd0;
      ind_q     <= 32'd0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
      vclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      h_req_q   <= h_req_d;
      v_req_q   <= v_req_d;
      vis_req_q <= vis_req_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ind_q     <= ind_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      fs_q      <= fs_d;
      vclk_q    <= vclk_d;
    end
  end

  assign indxpix     = x_q;
  assign indypix     = y_q;
  assign indpix      = ind_q;
  assign write_en    = 1'b0;
  assign vga_clk     = vclk_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b1;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign frame_start = fs_q;
  assign busy        = (state_q == SCAN);

endmodule

// File: tb/tb_vga_pix_reader.sv
// Directed bench: full-size timing instance for request/latency/reset checks and a
// shrunken-timing instance (24x14 ticks/frame) for whole-frame and en-drop checks.
module tb_vga_pix_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en_s = 1'b0;

  logic [7:0]  pr = 8'd0, pg = 8'd0, pb = 8'd0;
  logic [31:0] ix, iy, ip;
  logic        we, vclk, hs, vs, bn, sn, fs, busy;
  logic [7:0]  vr, vg, vb;

  logic [7:0]  pr_s = 8'd0, pg_s = 8'd0, pb_s = 8'd0;
  logic [31:0] ix_s, iy_s, ip_s;
  logic        we_s, vclk_s, hs_s, vs_s, bn_s, sn_s, fs_s, busy_s;
  logic [7:0]  vr_s, vg_s, vb_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_pix_reader dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .indxpix(ix), .indypix(iy), .indpix(ip), .write_en(we),
    .vga_clk(vclk), .vga_hs(hs), .vga_vs(vs), .vga_blank_n(bn), .vga_sync_n(sn),
    .vga_r(vr), .vga_g(vg), .vga_b(vb), .frame_start(fs), .busy(busy)
  );

  vga_pix_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en_s),
    .pix_r(pr_s), .pix_g(pg_s), .pix_b(pb_s),
    .indxpix(ix_s), .indypix(iy_s), .indpix(ip_s), .write_en(we_s),
    .vga_clk(vclk_s), .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s), .vga_sync_n(sn_s),
    .vga_r(vr_s), .vga_g(vg_s), .vga_b(vb_s), .frame_start(fs_s), .busy(busy_s)
  );

  // Stub memories: registered read, answer one clk after the address
  always @(posedge clk) begin
    pr   <= ix[7:0];
    pg   <= iy[7:0];
    pb   <= ip[7:0];
    pr_s <= ix_s[7:0];
    pg_s <= iy_s[7:0];
    pb_s <= ip_s[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, hs_low, vs_low, bn_hi, leak, maxip, fs_cnt;

    // Reset values
    en = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_fs", fs, 0);
    check("rst_indpix", ip, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_blank_n", bn, 0);
    check("rst_vga_b", vb, 0);
    check("rst_vga_clk", vclk, 0);
    check("rst_write_en", we, 0);
    check("rst_sync_n", sn, 1);

    // First tick issues (0,0) with a single frame_start pulse
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("t1_busy_pre", busy, 0);
    check("t1_fs_pre", fs, 0);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_fs", fs, 1);
    check("t1_ix", ix, 0);
    check("t1_iy", iy, 0);
    check("t1_ip", ip, 0);
    check("t1_vga_clk_hi", vclk, 1);
    @(negedge clk);
    check("t1_fs_drop", fs, 0);
    check("t1_vga_clk_lo", vclk, 0);

    // Request (5,2) and its DAC output one tick later
    n = 0;
    while (!(ix == 5 && iy == 2) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t2_reach_5_2", 32'(n < 5000), 1);
    check("t2_indpix", ip, 1285);
    @(negedge clk);
    @(negedge clk);
    check("t2_vga_b", vb, 8'h05);
    check("t2_vga_r", vr, 8'h05);
    check("t2_vga_g", vg, 8'h02);
    check("t2_blank_n", bn, 1);

    // One hsync pulse: 96 ticks = 192 clk
    n = 0;
    while (hs && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t3_hs_seen", 32'(n < 3000), 1);
    n = 0;
    while (!hs && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t3_hs_clks", n, 192);

    // Asynchronous reset mid-line
    n = 0;
    while (!(ix == 320 && iy == 3) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_320_3", 32'(n < 4000), 1);
    @(negedge clk);
    @(negedge clk);
    check("t5_pre_blank_n", bn, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_ix", ix, 0);
    check("t5_ip", ip, 0);
    check("t5_blank_n", bn, 0);
    check("t5_vga_b", vb, 0);
    check("t5_hs", hs, 1);
    check("t5_write_en", we, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (!fs && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_restart_clks", n, 2);
    check("t5_restart_ix", ix, 0);
    check("t5_restart_iy", iy, 0);
    check("t5_restart_we", we, 0);
    en = 1'b0;

    // Small instance: whole frame
    en_s = 1'b1;
    n = 0;
    while (!fs_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_first_fs", 32'(n < 100), 1);
    n = 0; hs_low = 0; vs_low = 0; bn_hi = 0; leak = 0; maxip = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hs_s) hs_low++;
      if (!vs_s) vs_low++;
      if (bn_s) bn_hi++;
      if (!bn_s && (vr_s != 0 || vg_s != 0 || vb_s != 0)) leak++;
      if (int'(ip_s) > maxip) maxip = int'(ip_s);
    end while (!fs_s && n < 2000);
    check("s_frame_clks", n, 672);
    check("s_hs_low_clks", hs_low, 84);
    check("s_vs_low_clks", vs_low, 96);
    check("s_blank_n_clks", bn_hi, 256);
    check("s_blank_leak", leak, 0);
    check("s_max_indpix", maxip, 127);

    // en drops at line 5: the frame completes, then the scan parks
    n = 0; fs_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (fs_s) fs_cnt++;
      if (iy_s == 5 && en_s) en_s = 1'b0;
    end while (busy_s && n < 2000);
    check("s4_busy_fall_clks", n, 670);
    check("s4_no_new_frame", fs_cnt, 0);
    check("s4_idle_ip", ip_s, 0);
    check("s4_idle_hs", hs_s, 1);
    check("s4_idle_vs", vs_s, 1);
    check("s4_idle_blank_n", bn_s, 0);
    check("s4_idle_vclk", vclk_s, 0);
    repeat (20) @(negedge clk);
    check("s4_still_idle", busy_s, 0);
    en_s = 1'b1;
    n = 0;
    while (!fs_s && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("s4_restart_seen", 32'(n < 10), 1);
    check("s4_restart_ix", ix_s, 0);
    check("s4_restart_iy", iy_s, 0);
    check("s4_restart_busy", busy_s, 1);
    check("s4_write_en", we_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
